// File: rtl/rf_pkg.sv
// Shared constants and FSM state type for the register-bank read port.
// Used by rf_read_mux and regfile_read_port.
package rf_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_NUM_REGS = 8;
  localparam int RF_ADDR_W   = 3;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_DUMP = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_mux.sv
// Combinational register select: index -> WIDTH-bit register value.
// With RF_BYPASS_EN defined, a same-cycle write to the selected register is forwarded.
module rf_read_mux
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*WIDTH-1:0] bank,
  input  logic [ADDR_W-1:0]         sel,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_idx,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          data
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
    assign regs[i] = bank[i*WIDTH +: WIDTH];
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    // NOTE: give every always_comb output a value on every path (default first) so no latch is inferred.
    data = regs[sel];
    if (wr_en && (wr_idx == sel)) data = wr_data;
  end
`else
  // The write snoop only matters when forwarding is built in.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_idx, wr_data};

  always_comb begin
    data = regs[sel];
  end
`endif

endmodule

// File: rtl/regfile_read_port.sv
// Two-operand read port with a registered 1-cycle output stage and a sequential dump mode.
// Optional same-cycle write forwarding is enabled by defining RF_BYPASS_EN.
module regfile_read_port
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REGS*WIDTH-1:0] regBank,
  input  logic                      regWrite,
  input  logic [ADDR_W-1:0]         writeReg,
  input  logic [WIDTH-1:0]          writeData,
  input  logic                      rdValid,
  output logic                      rdReady,
  input  logic [ADDR_W-1:0]         rdAddrA,
  input  logic [ADDR_W-1:0]         rdAddrB,
  input  logic                      dumpStart,
  output logic                      dumpBusy,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      outDump,
  output logic [WIDTH-1:0]          outA,
  output logic [WIDTH-1:0]          outB
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] dump_cnt, dump_cnt_next;
  logic              out_free;
  logic              load_rd;
  logic              load_dump;
  logic [WIDTH-1:0]  data_a, data_b, data_dump;
  logic [WIDTH-1:0]  next_a, next_b;

  rf_read_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_mux_a (
    .bank   (regBank),
    .sel    (rdAddrA),
    .wr_en  (regWrite),
    .wr_idx (writeReg),
    .wr_data(writeData),
    .data   (data_a)
  );

  rf_read_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_mux_b (
    .bank   (regBank),
    .sel    (rdAddrB),
    .wr_en  (regWrite),
    .wr_idx (writeReg),
    .wr_data(writeData),
    .data   (data_b)
  );

  rf_read_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_mux_dump (
    .bank   (regBank),
    .sel    (dump_cnt),
    .wr_en  (regWrite),
    .wr_idx (writeReg),
    .wr_data(writeData),
    .data   (data_dump)
  );

  // The output stage can take a new beat whenever it is empty or being drained this cycle.
  assign out_free = !outValid || outReady;
  assign rdReady  = (state == RF_IDLE) && !dumpStart && out_free;
  assign dumpBusy = (state == RF_DUMP);
  assign load_rd  = rdValid && rdReady;

  always_comb begin
    state_next    = state;
    dump_cnt_next = dump_cnt;
    load_dump     = 1'b0;
    case (state)
      RF_IDLE: begin
        if (dumpStart && out_free) state_next = RF_DUMP;
      end
      RF_DUMP: begin
        if (out_free) begin
          load_dump = 1'b1;
          if (dump_cnt == LAST_IDX) begin
            state_next    = RF_IDLE;
            dump_cnt_next = '0;
          end else begin
            dump_cnt_next = dump_cnt + 1'b1;
          end
        end
      end
      default: state_next = RF_IDLE;
    endcase
  end

  assign next_a = load_dump ? data_dump : data_a;
  assign next_b = load_dump ? {{(WIDTH - ADDR_W){1'b0}}, dump_cnt} : data_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RF_IDLE;
      dump_cnt <= '0;
    end else begin
      state    <= state_next;
      dump_cnt <= dump_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid <= 1'b0;
      outDump  <= 1'b0;
      outA     <= '0;
      outB     <= '0;
    end else if (load_rd || load_dump) begin
      outValid <= 1'b1;
      outDump  <= load_dump;
      outA     <= next_a;
      outB     <= next_b;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Scoreboard bench for regfile_read_port: directed stimulus pushes expected beats,
// an independent monitor pops and compares on every output handshake.
module tb_regfile_read_port;
  import rf_pkg::*;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*W-1:0] regBank;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [W-1:0]  writeData;
  logic          rdValid;
  logic          rdReady;
  logic [AW-1:0] rdAddrA;
  logic [AW-1:0] rdAddrB;
  logic          dumpStart;
  logic          dumpBusy;
  logic          outValid;
  logic          outReady;
  logic          outDump;
  logic [W-1:0]  outA;
  logic [W-1:0]  outB;

  regfile_read_port dut (
    .clk      (clk),
    .reset    (reset),
    .regBank  (regBank),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .rdValid  (rdValid),
    .rdReady  (rdReady),
    .rdAddrA  (rdAddrA),
    .rdAddrB  (rdAddrB),
    .dumpStart(dumpStart),
    .dumpBusy (dumpBusy),
    .outValid (outValid),
    .outReady (outReady),
    .outDump  (outDump),
    .outA     (outA),
    .outB     (outB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dump;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } beat_t;

  beat_t sb[$];
  int    passed = 0;
  int    total  = 0;
  bit    mon_en = 1'b0;

`ifdef RF_BYPASS_EN
  localparam logic [W-1:0] BYP_EXP = 16'hAAAA;
`else
  localparam logic [W-1:0] BYP_EXP = 16'h0001;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void push(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    beat_t e;
    e.dump = d;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endfunction

  function automatic void push_dump();
    for (int i = 0; i < N; i++) push(1'b1, W'(i * 16'h1111), W'(i));
  endfunction

  task automatic set_reg(input int idx, input logic [W-1:0] v);
    regBank[idx*W +: W] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && reset && outValid && outReady) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected_beat: got %0h expected no beat", {outDump, outA, outB});
      end else begin
        e = sb.pop_front();
        check("sb_beat", {outDump, outA, outB}, {e.dump, e.a, e.b});
      end
    end
  end

  task automatic wait_beat(input int k);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (outValid && outDump && (outB == W'(k))) found = 1'b1;
    end
    if (!found) begin
      total++;
      $display("FAIL wait_beat: dump beat %0d not seen within 50 cycles", k);
    end
  endtask

  // One read from an idle output stage; ends half a cycle after the result is checked.
  task automatic issue_read(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [W-1:0] ea, input logic [W-1:0] eb);
    rdAddrA = a;
    rdAddrB = b;
    rdValid = 1'b1;
    push(1'b0, ea, eb);
    @(negedge clk);
    check("rd_accept", rdReady, 1'b1);
    tick();
    rdValid = 1'b0;
    @(negedge clk);
    check("rd_latency", {outValid, outDump}, 2'b10);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    regBank   = '0;
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    rdValid   = 1'b0;
    rdAddrA   = '0;
    rdAddrB   = '0;
    dumpStart = 1'b0;
    outReady  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", {outValid, outDump, dumpBusy, outA, outB}, '0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdready", rdReady, 1'b1);
    tick();

    // Reset in the middle of a dump
    for (int i = 0; i < N; i++) set_reg(i, W'(i * 16'h1111));
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    wait_beat(3);
    reset = 1'b0;
    #1;
    check("midrst_out", {outValid, outDump, dumpBusy, outA, outB}, '0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_release", {rdReady, dumpBusy, outValid}, 3'b100);
    tick();
    mon_en = 1'b1;

    // Basic and same-index reads
    set_reg(2, 16'h1234);
    set_reg(5, 16'hBEEF);
    issue_read(3'd2, 3'd5, 16'h1234, 16'hBEEF);
    issue_read(3'd5, 3'd5, 16'hBEEF, 16'hBEEF);

    // Back-to-back reads at full rate
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin rdAddrA = 3'd0; rdAddrB = 3'd7; push(1'b0, 16'h0000, 16'h7777); end
        1: begin rdAddrA = 3'd5; rdAddrB = 3'd5; push(1'b0, 16'hBEEF, 16'hBEEF); end
        default: begin rdAddrA = 3'd6; rdAddrB = 3'd2; push(1'b0, 16'h6666, 16'h1234); end
      endcase
      rdValid = 1'b1;
      @(negedge clk);
      check("b2b_ready", rdReady, 1'b1);
      tick();
    end
    rdValid = 1'b0;
    tick();

    // Backpressure: result held, no accepts, then reload with no bubble
    outReady = 1'b0;
    issue_read(3'd2, 3'd5, 16'h1234, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {rdReady, outValid, outA, outB}, {2'b01, 16'h1234, 16'hBEEF});
      tick();
    end
    outReady = 1'b1;
    rdAddrA  = 3'd5;
    rdAddrB  = 3'd2;
    rdValid  = 1'b1;
    push(1'b0, 16'hBEEF, 16'h1234);
    @(negedge clk);
    check("stall_release_ready", rdReady, 1'b1);
    tick();
    rdValid = 1'b0;
    @(negedge clk);
    check("no_bubble", outValid, 1'b1);
    tick();

    // Same-cycle write to the read register, then a write to an unread register
    set_reg(3, 16'h0001);
    regWrite  = 1'b1;
    writeReg  = 3'd3;
    writeData = 16'hAAAA;
    issue_read(3'd3, 3'd1, BYP_EXP, 16'h1111);
    writeReg  = 3'd4;
    writeData = 16'h5555;
    issue_read(3'd2, 3'd5, 16'h1234, 16'hBEEF);
    regWrite  = 1'b0;

    // Dump wins over a same-cycle read; 2-cycle stall at beat 4
    for (int i = 0; i < N; i++) set_reg(i, W'(i * 16'h1111));
    rdAddrA   = 3'd1;
    rdAddrB   = 3'd1;
    rdValid   = 1'b1;
    dumpStart = 1'b1;
    @(negedge clk);
    check("dump_wins", rdReady, 1'b0);
    push_dump();
    tick();
    rdValid   = 1'b0;
    dumpStart = 1'b0;
    @(negedge clk);
    check("dump_busy", {dumpBusy, rdReady}, 2'b10);
    wait_beat(3);
    tick();
    outReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("dump_stall_hold", {outValid, outDump, outA, outB}, {2'b11, 16'h4444, 16'h0004});
      tick();
    end
    outReady = 1'b1;
    wait_beat(7);
    check("dump_busy_fall", dumpBusy, 1'b0);
    tick();

    // dumpStart ignored while the output is stalled, taken once it drains
    outReady = 1'b0;
    issue_read(3'd2, 3'd5, 16'h2222, 16'h5555);
    dumpStart = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("prio_blocked", {dumpBusy, rdReady}, 2'b00);
      tick();
    end
    outReady = 1'b1;
    push_dump();
    tick();
    dumpStart = 1'b0;
    @(negedge clk);
    check("prio_started", dumpBusy, 1'b1);
    wait_beat(7);
    check("prio_busy_fall", dumpBusy, 1'b0);
    tick();

    // Drain
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
Read side of the register bank whose registers are written through the per-register write-enable / decoder-select path.
- Takes the flattened register outputs plus a snoop of the write port.
- Serves two-operand read requests over a valid/ready handshake with a registered, 1-cycle-latency result.
- Provides a sequential dump mode that streams every register out on the same output channel.

Parameters:
WIDTH, 16, bits per register
NUM_REGS, 8, registers in the bank (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register index width (localparam, derived)

Ports:
clk  input  1  rising-edge clock, same clock as the register bank
reset  input  1  asynchronous, active-low reset
regBank  input  NUM_REGS*WIDTH  all register outputs; register i at [i*WIDTH +: WIDTH]
regWrite  input  1  write-port enable snoop
writeReg  input  ADDR_W  index of register being written this cycle
writeData  input  WIDTH  data being written this cycle
rdValid  input  1  read request valid
rdReady  output  1  read request accepted when rdValid && rdReady
rdAddrA  input  ADDR_W  operand A index
rdAddrB  input  ADDR_W  operand B index
dumpStart  input  1  request a full-bank dump
dumpBusy  output  1  dump in progress
outValid  output  1  result valid
outReady  input  1  consumer accepts result
outDump  output  1  current result is a dump beat
outA  output  WIDTH  operand A data, or dump register data
outB  output  WIDTH  operand B data, or zero-extended dump index

Behaviour:
- Reset (async, reset==0): state IDLE; outValid, outDump, dumpBusy, outA, outB all 0; dump counter 0. A pending beat is dropped; no partial output after release.
- Output stage: a single register. outValid holds, with outA/outB/outDump stable, until outValid && outReady. The stage may reload in the same cycle it is emptied.
- rdReady = (state==IDLE) && !dumpStart && (!outValid || outReady). It is combinational and never depends on rdValid.
- Read: on accept, outA <= data[rdAddrA] and outB <= data[rdAddrB]; outValid=1 and outDump=0 the next cycle. Latency is 1 cycle. Back-to-back accepts sustain 1 read/cycle when outReady=1.
- rdAddrA==rdAddrB is legal; both outputs carry the same value.
- data[i] is regBank slice i, subject to the bypass rule under Optional Feature.
- States: IDLE, DUMP.
  - IDLE -> DUMP: on dumpStart when (!outValid || outReady). dumpStart wins over a same-cycle rdValid. dumpStart while the output is stalled is ignored (level, sampled each cycle).
  - DUMP: dumpBusy=1 and rdReady=0. Beat k loads outA=data[k], outB=k (zero-extended) and outDump=1. k runs 0..NUM_REGS-1; the next beat loads only when the output stage frees.
  - DUMP -> IDLE: the cycle the last beat (k=NUM_REGS-1) is loaded. The counter wraps to 0. dumpBusy drops when the state returns to IDLE.
  - dumpStart in DUMP is ignored.
- Writes concurrent with a dump are captured per beat as they occur; the dump is not a snapshot.
- regWrite with an index not currently read has no effect.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: when regWrite && writeReg==i in the load cycle, data[i]=writeData, so the result reflects the write landing at that same edge.
- Undefined: data[i] is always the regBank slice, i.e. the pre-write value.
- Applies to reads and dump beats alike.

Decomposition:
- Shared package rf_pkg: RF_WIDTH=16, RF_NUM_REGS=8, RF_ADDR_W=3, and the state enum (RF_IDLE, RF_DUMP).
- One natural sub-module, rf_read_mux: a combinational index -> WIDTH select with the optional bypass. It is instantiated three times (A, B, dump).
- The top holds the FSM, the dump counter and the output register.

Test Plan:
- Reset mid-dump: start a dump, assert reset at beat 3 -> all outputs 0 immediately; after release the state is IDLE and rdReady=1.
- Basic read: regBank reg2=16'h1234, reg5=16'hBEEF; rdValid with A=2, B=5, outReady=1 -> next cycle outValid=1, outA=16'h1234, outB=16'hBEEF, outDump=0. Same-index read A=B=5 -> outA=outB=16'hBEEF.
- Backpressure: outReady=0 for 3 cycles after a read -> outA/outB stable, rdReady=0. outReady=1 with a new rdValid the same cycle -> the new result appears next cycle with no bubble.
- Bypass: reg3=16'h0001 with regWrite, writeReg=3, writeData=16'hAAAA in the accept cycle, A=3 -> outA=16'hAAAA with RF_BYPASS_EN, 16'h0001 without.
- Dump: regs hold i*16'h1111; dumpStart with rdValid also high -> rdValid not accepted. Eight beats follow, outB=0..7, outA=16'h0000..16'h7777, outDump=1; a 2-cycle outReady stall at beat 4 repeats beat 4. dumpBusy falls after beat 7 is loaded.
- Priority: dumpStart while outValid=1 and outReady=0 -> no dump starts; dumpStart held until outReady=1 -> the dump starts that cycle.
